// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the VGA raster timing generator.
//   - Default 640x480@60 timing (100 MHz clock, 25 MHz pixel rate).
//   - h_total / v_total: full line / frame length from the four timing fields.
//   - FRAME_CNT_W: width of the optional frame counter (VGA_FRAME_CNT_EN).
package vga_pkg;

    localparam int unsigned DEF_PIX_DIV  = 4;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_CNT_W    = 11;

    localparam int unsigned FRAME_CNT_W  = 16;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_clk_en.sv
// pix_clk_en: pixel-rate clock enable derived from the system clock.
//   clk    : system clock
//   clr    : synchronous active-high reset
//   pix_en : high for one clk cycle in every PIX_DIV, first in the PIX_DIV-th cycle after reset
module pix_clk_en #(
    parameter int unsigned PIX_DIV = 4
) (
    input  logic clk,
    input  logic clr,
    output logic pix_en
);

    localparam int unsigned DivW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(PIX_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic            pix_en_q, pix_en_d;

    // The strobe is registered, so it is raised when the divider is about to reach its last
    // phase; with PIX_DIV=1 the divider never moves and the strobe stays high.
    always_comb begin
        div_d    = (div_q == DivMax) ? '0 : div_q + 1'b1;
        pix_en_d = (div_d == DivMax);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
        end
    end

    assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator on the system clock.
//   clk, clr    : system clock, synchronous active-high reset
//   pix_en      : pixel strobe (one clk cycle every PIX_DIV)
//   hc, vc      : pixel / line index, 0 = first active pixel / line
//   hsync/vsync : sync pulses with active levels HS_POL / VS_POL
//   vidon       : inside the visible area
//   line_start  : one-clk pulse on the first cycle showing hc = 0
//   frame_start : one-clk pulse on the first cycle showing hc = 0, vc = 0
//   frame_cnt   : 16-bit wrapping frame counter, present only when VGA_FRAME_CNT_EN is defined
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned PIX_DIV  = DEF_PIX_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             clr,
    output logic             pix_en,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             hsync,
    output logic             vsync,
    output logic             vidon,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

    localparam int unsigned HTotal = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned VTotal = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] HLast   = CNT_W'(HTotal - 1);
    localparam logic [CNT_W-1:0] VLast   = CNT_W'(VTotal - 1);
    localparam logic [CNT_W-1:0] HActive = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VActive = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HsStart = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HsStop  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VsStart = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VsStop  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, vidon_q, vidon_d;
    logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
`endif

    pix_clk_en #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_clk_en (
        .clk    (clk),
        .clr    (clr),
        .pix_en (pix_en)
    );

    // Decodes are taken from the next counter values so that sync/vidon register on the
    // same edge as the position they describe.
    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        vidon_d       = vidon_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (pix_en) begin
            if (hc_q == HLast) begin
                hc_d = '0;
                vc_d = (vc_q == VLast) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
            hsync_d       = (hc_d >= HsStart && hc_d < HsStop) ? HS_POL : ~HS_POL;
            vsync_d       = (vc_d >= VsStart && vc_d < VsStop) ? VS_POL : ~VS_POL;
            vidon_d       = (hc_d < HActive) && (vc_d < VActive);
            line_start_d  = (hc_d == '0);
            frame_start_d = (hc_d == '0) && (vc_d == '0);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end
`endif

    // Reset parks the raster on the last pixel of the frame (inside both back porches), so
    // the first pixel strobe lands on (0,0).
    always_ff @(posedge clk) begin
        if (clr) begin
            hc_q          <= HLast;
            vc_q          <= VLast;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            vidon_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt_q   <= '0;
`endif
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            vidon_q       <= vidon_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vidon       = vidon_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
`ifdef VGA_FRAME_CNT_EN
    assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, a small PIX_DIV=3 raster with
// positive hsync, and a tiny PIX_DIV=1 raster) checked every cycle against a model that
// derives the raster position from elapsed cycles, plus literal timing expectations.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        pix_en;
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hsync;
        logic        vsync;
        logic        vidon;
        logic        line_start;
        logic        frame_start;
        logic [15:0] frame_cnt;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr_a, clr_b, clr_c;
    logic pe_a, hs_a, vs_a, vo_a, ls_a, fs_a;
    logic pe_b, hs_b, vs_b, vo_b, ls_b, fs_b;
    logic pe_c, hs_c, vs_c, vo_c, ls_c, fs_c;
    logic [10:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
    logic [15:0] fc_a, fc_b, fc_c;

    int n_cmp = 0;
    int n_err = 0;

    vga_timing_gen u_dut_a (
        .clk(clk), .clr(clr_a), .pix_en(pe_a), .hc(hc_a), .vc(vc_a), .hsync(hs_a),
        .vsync(vs_a), .vidon(vo_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_a)
`endif
    );

    vga_timing_gen #(
        .PIX_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(11)
    ) u_dut_b (
        .clk(clk), .clr(clr_b), .pix_en(pe_b), .hc(hc_b), .vc(vc_b), .hsync(hs_b),
        .vsync(vs_b), .vidon(vo_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_b)
`endif
    );

    vga_timing_gen #(
        .PIX_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(11)
    ) u_dut_c (
        .clk(clk), .clr(clr_c), .pix_en(pe_c), .hc(hc_c), .vc(vc_c), .hsync(hs_c),
        .vsync(vs_c), .vidon(vo_c), .line_start(ls_c), .frame_start(fs_c)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_c)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign fc_a = '0;
    assign fc_b = '0;
    assign fc_c = '0;
`endif

    // Expected outputs t cycles after the reset edge (t = 0 is the reset-state cycle).
    // Pixel strobe rule: high in cycle t >= 1 when t+1 is a multiple of d; p counts the
    // strobes already consumed, and the raster starts one position before (0,0).
    function automatic obs_t model(input int t, input int d,
                                   input int ha, input int hfp, input int hs, input int hbp,
                                   input int va, input int vfp, input int vs, input int vbp,
                                   input bit hp, input bit vp);
        obs_t e;
        int   ht, vt, tot, p, lin, h, v;
        bit   moved;
        ht  = ha + hfp + hs + hbp;
        vt  = va + vfp + vs + vbp;
        tot = ht * vt;
        if (d == 1) p = (t >= 1) ? t - 1 : 0;
        else        p = t / d;
        lin   = (p + tot - 1) % tot;
        h     = lin % ht;
        v     = lin / ht;
        moved = (t >= 2) && (t % d == 0);
        e.pix_en      = (t >= 1) && ((t + 1) % d == 0);
        e.hc          = 11'(h);
        e.vc          = 11'(v);
        e.hsync       = (h >= ha + hfp && h < ha + hfp + hs) ? hp : ~hp;
        e.vsync       = (v >= va + vfp && v < va + vfp + vs) ? vp : ~vp;
        e.vidon       = (h < ha) && (v < va);
        e.line_start  = moved && (h == 0);
        e.frame_start = moved && (h == 0) && (v == 0);
        e.frame_cnt   = (p == 0) ? 16'd0 : 16'(((p - 1) / tot + 1) % 65536);
`ifndef VGA_FRAME_CNT_EN
        e.frame_cnt   = '0;
`endif
        return e;
    endfunction

    task automatic check_obs(input string name, input int t, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got pe=%b hc=%0d vc=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%0d want pe=%b hc=%0d vc=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%0d",
                     name, t, act.pix_en, act.hc, act.vc, act.hsync, act.vsync, act.vidon,
                     act.line_start, act.frame_start, act.frame_cnt, exp.pix_en, exp.hc, exp.vc,
                     exp.hsync, exp.vsync, exp.vidon, exp.line_start, exp.frame_start,
                     exp.frame_cnt);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Cycles since each instance's last reset edge.
    int t_a, t_b, t_c;
    bit ok_a = 1'b0, ok_b = 1'b0, ok_c = 1'b0;

    always @(posedge clk) begin
        if (clr_a) begin t_a <= 0; ok_a <= 1'b1; end else t_a <= t_a + 1;
        if (clr_b) begin t_b <= 0; ok_b <= 1'b1; end else t_b <= t_b + 1;
        if (clr_c) begin t_c <= 0; ok_c <= 1'b1; end else t_c <= t_c + 1;
    end

    always @(negedge clk) begin
        if (ok_a) check_obs("model_a", t_a,
            {pe_a, hc_a, vc_a, hs_a, vs_a, vo_a, ls_a, fs_a, fc_a},
            model(t_a, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
        if (ok_b) check_obs("model_b", t_b,
            {pe_b, hc_b, vc_b, hs_b, vs_b, vo_b, ls_b, fs_b, fc_b},
            model(t_b, 3, 8, 2, 3, 2, 5, 1, 2, 2, 1'b1, 1'b0));
        if (ok_c) check_obs("model_c", t_c,
            {pe_c, hc_c, vc_c, hs_c, vs_c, vo_c, ls_c, fs_c, fc_c},
            model(t_c, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0));
    end

    initial begin
        clr_a = 1'b1;
        clr_b = 1'b1;
        clr_c = 1'b1;
        repeat (3) @(negedge clk);
        check_val("a_reset_hc", int'(hc_a), 799);
        check_val("a_reset_vc", int'(vc_a), 524);
        check_val("a_reset_vidon", int'(vo_a), 0);
        check_val("a_reset_hsync", int'(hs_a), 1);
        check_val("a_reset_vsync", int'(vs_a), 1);
        check_val("a_reset_pix_en", int'(pe_a), 0);
        clr_a = 1'b0;
        clr_b = 1'b0;
        clr_c = 1'b0;

        fork
            begin : thr_a
                int k, n;
                // The release cycle counts as cycle 1.
                k = 1;
                while (pe_a !== 1'b1 && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                check_val("a_first_pix_en_cycle", k, 4);
                @(negedge clk);
                check_val("a_first_hc", int'(hc_a), 0);
                check_val("a_first_vc", int'(vc_a), 0);
                check_val("a_first_vidon", int'(vo_a), 1);
                check_val("a_first_frame_start", int'(fs_a), 1);
                check_val("a_first_line_start", int'(ls_a), 1);
                @(negedge clk);
                check_val("a_frame_start_width", int'(fs_a), 0);
                k = 1;
                while (hs_a !== 1'b0 && k < 5000) begin
                    @(negedge clk);
                    k++;
                end
                check_val("a_hsync_fall_after_line_start", k, 2624);
                n = 0;
                while (hs_a === 1'b0 && n < 5000) begin
                    n++;
                    @(negedge clk);
                    k++;
                end
                check_val("a_hsync_low_cycles", n, 384);
                while (ls_a !== 1'b1 && k < 5000) begin
                    @(negedge clk);
                    k++;
                end
                check_val("a_line_period_1", k, 3200);
                @(negedge clk);
                k = 1;
                while (ls_a !== 1'b1 && k < 5000) begin
                    @(negedge clk);
                    k++;
                end
                check_val("a_line_period_2", k, 3200);
                repeat (700) @(negedge clk);
                clr_a = 1'b1;
                @(negedge clk);
                clr_a = 1'b0;
                check_val("a_midreset_hc", int'(hc_a), 799);
                check_val("a_midreset_vc", int'(vc_a), 524);
                check_val("a_midreset_vidon", int'(vo_a), 0);
                check_val("a_midreset_hsync", int'(hs_a), 1);
                check_val("a_midreset_pix_en", int'(pe_a), 0);
                check_val("a_midreset_line_start", int'(ls_a), 0);
                k = 0;
                while (fs_a !== 1'b1 && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                check_val("a_frame_start_after_reset", k, 4);
                repeat (50) @(negedge clk);
            end
            begin : thr_b
                int k;
                repeat (1000) @(negedge clk);
                clr_b = 1'b1;
                @(negedge clk);
                clr_b = 1'b0;
                check_val("b_midreset_hc", int'(hc_b), 14);
                check_val("b_midreset_vc", int'(vc_b), 9);
                check_val("b_midreset_hsync", int'(hs_b), 0);
                check_val("b_midreset_vsync", int'(vs_b), 1);
                check_val("b_midreset_vidon", int'(vo_b), 0);
                check_val("b_midreset_pix_en", int'(pe_b), 0);
                check_val("b_midreset_frame_cnt", int'(fc_b), 0);
                k = 0;
                while (fs_b !== 1'b1 && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                check_val("b_frame_start_after_reset", k, 3);
                repeat (1000) @(negedge clk);
            end
            begin : thr_c
                int k, vcnt, pcnt;
                k = 0;
                while (ls_c !== 1'b1 && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                check_val("c_first_frame_start", int'(fs_c), 1);
`ifdef VGA_FRAME_CNT_EN
                check_val("c_frame_cnt_first", int'(fc_c), 1);
`endif
                @(negedge clk);
                k = 1;
                while (ls_c !== 1'b1 && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                check_val("c_line_period", k, 8);
                while (fs_c !== 1'b1 && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                k = 0;
                vcnt = 0;
                pcnt = 0;
                do begin
                    vcnt += int'(vo_c);
                    pcnt += int'(pe_c);
                    @(negedge clk);
                    k++;
                end while (fs_c !== 1'b1 && k < 200);
                check_val("c_frame_period", k, 48);
                check_val("c_vidon_cycles", vcnt, 12);
                check_val("c_pix_en_cycles", pcnt, 48);
`ifdef VGA_FRAME_CNT_EN
                check_val("c_frame_cnt_third", int'(fc_c), 3);
`endif
                repeat (200) @(negedge clk);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
